// File: rtl/inst_cache_sa_pkg.sv
// Shared defaults and FSM state encoding for the set-associative instruction cache.
package inst_cache_sa_pkg;

  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_WAYS       = 2;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_ADDR_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } icache_state_t;

  // Width helper that never returns zero, so 1-entry fields still get a bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inst_cache_sa_way.sv
// One cache way: valid bits, tag array and line data with combinational read
// and a single write port (word strobe for data, tag strobe for tag+valid).
module inst_cache_sa_way
  import inst_cache_sa_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = $clog2(SETS),
  parameter int BEAT_W     = min1_clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BEAT_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_word,
  input  logic              data_we,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              valid_in
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int AW     = IDX_W + WOFF_W;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS*LINE_WORDS];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign rd_ptr   = (AW'(rd_idx) << WOFF_W) | AW'(rd_word);
  assign wr_ptr   = (AW'(wr_idx) << WOFF_W) | AW'(wr_word);
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_ptr];

  // Invalidate-all wins over a same-cycle install so a flushed refill never sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid <= '0;
    else if (clr_all) valid <= '0;
    else if (tag_we)  valid[wr_idx] <= valid_in;
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tags[wr_idx] <= wr_tag;
    if (data_we) data[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/inst_cache_sa.sv
// Set-associative instruction cache: N ways, multi-word lines, round-robin
// replacement, refill FSM and fence.i flush. Optional counters: ICACHE_PERF_EN.
module inst_cache_sa
  import inst_cache_sa_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int WAYS       = ICACHE_WAYS,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int ADDR_W     = ICACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = 2 + WOFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BEAT_W = min1_clog2(LINE_WORDS);
  localparam int WAY_W  = min1_clog2(WAYS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  icache_state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic [BEAT_W-1:0] beat;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  rr [SETS];
  logic              flush_pend;
  logic              req_live;

  logic [ADDR_W-1:0] lk_addr;
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [BEAT_W-1:0] lk_word;

  logic [WAYS-1:0]   way_valid;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [31:0]       way_data [WAYS];

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  vic_sel;
  logic              do_hit, do_miss, last_beat, data_we;

  function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
    return (WAYS > 1) ? WAY_W'((int'(p) + 1) % WAYS) : '0;
  endfunction

  // Lookups use the live fetch address while idle, the latched miss address otherwise.
  assign lk_addr = (state == ST_IDLE) ? if_addr : req_addr;
  assign lk_idx  = lk_addr[OFF_W +: IDX_W];
  assign lk_tag  = lk_addr[ADDR_W-1 -: TAG_W];
  assign lk_word = BEAT_W'(lk_addr >> 2) & BEAT_W'(LINE_WORDS - 1);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    inst_cache_sa_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .BEAT_W     (BEAT_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (lk_idx),
      .rd_word  (lk_word),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_data  (way_data[g]),
      .clr_all  (flush),
      .wr_idx   (lk_idx),
      .wr_word  (beat),
      .data_we  (data_we && (victim == WAY_W'(g))),
      .wr_data  (mem_data),
      .tag_we   (last_beat && (victim == WAY_W'(g))),
      .wr_tag   (lk_tag),
      .valid_in (!flush_pend)
    );
  end

  // Tag compare across ways; victim is the lowest invalid way, else the set's RR pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_sel = rr[lk_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) vic_sel = WAY_W'(w);
    end
    if (flush) vic_sel = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    last_beat = 1'b0;
    data_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req && !if_valid) begin
          do_hit  = hit && !flush;
          do_miss = !(hit && !flush);
        end
        if (do_miss) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        data_we   = mem_valid;
        last_beat = mem_valid && (beat == LAST_BEAT);
        if (last_beat) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_inst    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      req_addr   <= '0;
      beat       <= '0;
      victim     <= '0;
      flush_pend <= 1'b0;
      req_live   <= 1'b0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      if_valid <= do_hit || ((state == ST_RESP) && req_live);
      if (do_hit)                           if_inst <= way_data[hit_way];
      else if ((state == ST_RESP) && req_live) if_inst <= way_data[victim];

      if (do_miss) begin
        mem_req  <= 1'b1;
        mem_addr <= {if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        req_addr <= if_addr;
        beat     <= '0;
        victim   <= vic_sel;
        req_live <= 1'b1;
      end else if (data_we) begin
        beat <= beat + BEAT_W'(1);
        if (last_beat) mem_req  <= 1'b0;
        else           mem_addr <= mem_addr + ADDR_W'(4);
      end

      if ((state != ST_IDLE) && !if_req) req_live <= 1'b0;

      // A flush that lands while a refill is outstanding keeps that line from being validated.
      if (state == ST_RESP)                flush_pend <= 1'b0;
      else if (flush && (state == ST_REFILL)) flush_pend <= 1'b1;

      if (last_beat) rr[lk_idx] <= rr_next(rr[lk_idx]);
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (do_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign perf_hit  = hit_cnt;
  assign perf_miss = miss_cnt;
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_inst_cache_sa.sv
// Scoreboard bench for inst_cache_sa: random fetch traffic against a line-level
// cache model, plus directed cold/hit/eviction/stall/flush/reset scenarios.
module tb_inst_cache_sa;

  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int LW   = 4;
  localparam int OFF  = 4;
  localparam int IDX  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;

  inst_cache_sa #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .if_valid(if_valid), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data), .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_fixed = 0;

  logic [31:0] resp_q[$];
  logic [31:0] mem_q[$];

  // Reference model: per set, which tags each way holds plus a replacement pointer.
  logic [31:0] m_tag [SETS][WAYS];
  bit          m_val [SETS][WAYS];
  int          m_rr  [SETS];
  int          exp_hits;
  int          exp_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] ad);
    if (ad >= 32'h1000 && ad < 32'h1010) return 32'hA0 + ((ad - 32'h1000) >> 2);
    return 32'hC0DE_0000 ^ (ad * 32'd7);
  endfunction

  task automatic model_clear_valid();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_valid();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model_fetch(input logic [31:0] a, input bit fl_first, input bit fl_mid,
                             input bit abort, output bit hit);
    int set, way;
    logic [31:0] tag, base;
    set  = int'((a >> OFF) % SETS);
    tag  = a >> (OFF + IDX);
    base = a & ~32'(LW * 4 - 1);
    hit  = 1'b0;
    if (fl_first) model_clear_valid();
    else
      for (int w = 0; w < WAYS; w++)
        if (m_val[set][w] && m_tag[set][w] == tag) hit = 1'b1;
    if (hit) begin
      exp_hits++;
      resp_q.push_back(mem_word(a & ~32'h3));
      return;
    end
    exp_misses++;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_val[set][w] && way < 0) way = w;
    if (way < 0) way = m_rr[set];
    for (int b = 0; b < LW; b++) mem_q.push_back(base + 32'(4 * b));
    if (!abort) resp_q.push_back(mem_word(a & ~32'h3));
    m_rr[set] = (m_rr[set] + 1) % WAYS;
    if (fl_mid) model_clear_valid();
    else begin
      m_val[set][way] = 1'b1;
      m_tag[set][way] = tag;
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef ICACHE_PERF_EN
    check({tag, "_perf_hit"}, perf_hit, 32'(exp_hits));
    check({tag, "_perf_miss"}, perf_miss, 32'(exp_misses));
`else
    check({tag, "_perf_hit"}, perf_hit, 32'd0);
    check({tag, "_perf_miss"}, perf_miss, 32'd0);
`endif
  endtask

  // Memory responder: stall_fixed cycles before each beat, or random when negative.
  initial begin
    int wcnt, tgt;
    mem_valid = 1'b0;
    mem_data  = '0;
    wcnt = 0;
    tgt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= tgt) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(mem_addr);
          wcnt = 0;
          tgt  = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
        end else begin
          mem_valid = 1'b0;
          wcnt++;
        end
      end else begin
        mem_valid = 1'b0;
        wcnt = 0;
        tgt  = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: responses and refill addresses popped from the scoreboard queues.
  initial begin
    logic        prev_req, prev_vld;
    logic [31:0] prev_addr, e;
    prev_req = 1'b0;
    prev_vld = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_valid) begin
          if (resp_q.size() == 0) check("unexpected_if_valid", 32'd1, 32'd0);
          else begin
            e = resp_q.pop_front();
            check("if_inst", if_inst, e);
          end
        end
        if (mem_req && mem_valid) begin
          if (mem_q.size() == 0) check("unexpected_mem_beat", mem_addr, 32'hFFFF_FFFF);
          else begin
            e = mem_q.pop_front();
            check("mem_addr", mem_addr, e);
          end
        end
        if (prev_req && !prev_vld && mem_req) check("mem_addr_stable", mem_addr, prev_addr);
      end
      prev_req  = mem_req && rst_n;
      prev_vld  = mem_valid;
      prev_addr = mem_addr;
    end
  end

  task automatic fetch(input logic [31:0] a, input bit fl_first, input bit fl_mid, input bit abort);
    bit exp_hit, ab, got, saw, fdone, fin;
    int cnt;
    model_fetch(a, fl_first, fl_mid, abort, exp_hit);
    ab = abort && !exp_hit;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = a;
    flush = fl_first;
    cnt = 0; got = 0; saw = 0; fdone = 0; fin = 0;
    while (!fin && cnt < 400) begin
      @(negedge clk);
      cnt++;
      flush = 1'b0;
      if (mem_req) saw = 1'b1;
      if (fl_mid && mem_req && !fdone) begin
        flush = 1'b1;
        fdone = 1'b1;
      end
      if (ab && mem_req) if_req = 1'b0;
      if (!ab && if_valid) begin
        got = 1'b1;
        fin = 1'b1;
      end
      if (ab && saw && !mem_req) fin = 1'b1;
    end
    if_req = 1'b0;
    flush  = 1'b0;
    if (!fin) check("fetch_timeout", 32'(cnt), 32'd0);
    check("refill_taken", 32'(saw), 32'(!exp_hit));
    if (got && exp_hit) check("hit_latency", 32'(cnt), 32'd1);
    if (got && !exp_hit && stall_fixed >= 0)
      check("miss_latency", 32'(cnt), 32'(2 + LW * (stall_fixed + 1)));
    if (ab) repeat (3) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear_valid();
  endtask

  initial begin
    int beats, r, guard;
    logic [31:0] a;
    rst_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check_perf("rst");
    rst_n = 1'b1;

    stall_fixed = 0;
    fetch(32'h0000_1004, 0, 0, 0);
    fetch(32'h0000_100C, 0, 0, 0);
    check_perf("after_hit");

    fetch(32'h0000_2000, 0, 0, 0);
    fetch(32'h0000_3000, 0, 0, 0);
    fetch(32'h0000_2000, 0, 0, 0);
    fetch(32'h0000_1000, 0, 0, 0);

    stall_fixed = 5;
    fetch(32'h0000_5008, 0, 0, 0);
    stall_fixed = 0;

    fetch(32'h0000_4000, 0, 1, 0);
    fetch(32'h0000_4000, 0, 0, 0);
    fetch(32'h0000_4004, 1, 0, 0);
    fetch(32'h0000_4008, 0, 0, 0);
    fetch(32'h0000_8000, 0, 0, 1);
    fetch(32'h0000_8008, 0, 0, 0);
    check_perf("directed");

    stall_fixed = -1;
    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      r = int'($urandom_range(0, 19));
      if (r == 0) do_flush();
      else if (r == 1) fetch(a, 0, 0, 1);
      else if (r == 2) fetch(a, 1, 0, 0);
      else if (r == 3) fetch(a, 0, 1, 0);
      else fetch(a, 0, 0, 0);
    end
    check_perf("random");

    // Reset in the middle of a refill, during beat 2.
    stall_fixed = 0;
    for (int b = 0; b < LW; b++) mem_q.push_back(32'h0000_7000 + 32'(4 * b));
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_7000;
    beats = 0;
    guard = 0;
    while (beats < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (mem_req && mem_valid) beats++;
    end
    check("rst_test_beats", 32'(beats), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_if_valid", 32'(if_valid), 32'd0);
    if_req = 1'b0;
    mem_q.delete();
    resp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst2_mem_addr", mem_addr, 32'd0);
    check_perf("rst2");
    rst_n = 1'b1;
    fetch(32'h0000_1000, 0, 0, 0);
    fetch(32'h0000_1008, 0, 0, 0);
    check_perf("final");

    repeat (4) @(negedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
